oe_sort_pipe: RTL and testbench

OE_SORT_PIPE -- requirements
Module: oe_sort_pipe

---
 rtl/oe_sort_pipe_pkg.sv | 27 ++
 rtl/oe_sort_pipe_if.sv | 44 ++++
 rtl/oe_sort_pipe_cas_stage.sv | 112 +++++++++++
 rtl/oe_sort_pipe.sv | 95 +++++++++
 tb/tb_oe_sort_pipe.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oe_sort_pipe_pkg.sv
// sort_pkg -- shared definitions for the odd-even transposition sorter.
//
// Contents:
//   idx_w()     : width of an element position tag, max(1, $clog2(n)).
//   stage_rec_t : layout of one pipeline stage record (valid, desc, data,
//                 idx), sized for the largest legal configuration
//                 (64 x 32-bit). Each stage stores the same fields, trimmed
//                 to DATA_N x DATA_W, with idx kept only when SORT_IDX_EN
//                 is defined.
package sort_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_W     = 32;
  localparam int MAX_IDX_W = 6;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                                valid;
    logic                                desc;
    logic [MAX_N-1:0][MAX_W-1:0]         data;
    logic [MAX_N-1:0][MAX_IDX_W-1:0]     idx;
  } stage_rec_t;

endpackage

// File: rtl/oe_sort_pipe_if.sv
// oe_sort_pipe_if -- vector stream interface of the sorter.
//
// Signals:
//   in_valid / in_ready / in_data / in_desc : unsorted vector in (desc=1
//                                             requests descending order)
//   out_valid / out_ready / out_data        : sorted vector out
//   out_idx                                 : original position of each
//                                             out_data element (only with
//                                             macro SORT_IDX_EN)
// Modports: slave = sorter side, master = producer/consumer side.
interface oe_sort_pipe_if #(
  parameter int DATA_N = 8,
  parameter int DATA_W = 8
);

  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_N-1:0][DATA_W-1:0]  in_data;
  logic                           in_desc;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_N-1:0][DATA_W-1:0]  out_data;
`ifdef SORT_IDX_EN
  localparam int IDX_W = sort_pkg::idx_w(DATA_N);
  logic [DATA_N-1:0][IDX_W-1:0]   out_idx;
`endif

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data
`ifdef SORT_IDX_EN
    , output out_idx
`endif
  );

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data
`ifdef SORT_IDX_EN
    , input out_idx
`endif
  );

endinterface

// File: rtl/oe_sort_pipe_cas_stage.sv
// sort_cas_stage -- one registered compare-exchange stage.
//
// Even stage (ODD=0) exchanges pairs (0,1),(2,3)..; odd stage (ODD=1)
// exchanges (1,2),(3,4)... Swaps only on strict inequality so equal keys
// keep their order. The exchange is applied to the incoming vector and the
// result is registered together with valid, desc and (with SORT_IDX_EN)
// the position tags.
//
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   up_valid/up_ready/up_desc/up_data/up_idx : from previous stage
//   dn_valid/dn_ready/dn_desc/dn_data/dn_idx : to next stage
module sort_cas_stage
  import sort_pkg::*;
#(
  parameter int DATA_N = 8,
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      up_valid,
  output logic                                      up_ready,
  input  logic                                      up_desc,
  input  logic [DATA_N-1:0][DATA_W-1:0]             up_data,
`ifdef SORT_IDX_EN
  input  logic [DATA_N-1:0][idx_w(DATA_N)-1:0]      up_idx,
  output logic [DATA_N-1:0][idx_w(DATA_N)-1:0]      dn_idx,
`endif
  output logic                                      dn_valid,
  input  logic                                      dn_ready,
  output logic                                      dn_desc,
  output logic [DATA_N-1:0][DATA_W-1:0]             dn_data
);

  logic                           valid_q, valid_d;
  logic                           desc_q, desc_d;
  logic [DATA_N-1:0][DATA_W-1:0]  data_q, data_d;
  logic [DATA_N-1:0][DATA_W-1:0]  xch_data;
  logic                           load;
`ifdef SORT_IDX_EN
  localparam int IDX_W = idx_w(DATA_N);
  logic [DATA_N-1:0][IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_N-1:0][IDX_W-1:0]   xch_idx;
`endif

  // Bubble-collapsing: accept whenever empty or the held vector leaves now.
  assign up_ready = !valid_q || dn_ready;
  assign load     = up_valid && up_ready;

  always_comb begin
    xch_data = up_data;
`ifdef SORT_IDX_EN
    xch_idx  = up_idx;
`endif
    for (int i = (ODD ? 1 : 0); i < DATA_N - 1; i += 2) begin
      if (up_desc ? (up_data[i] < up_data[i+1]) : (up_data[i] > up_data[i+1])) begin
        xch_data[i]   = up_data[i+1];
        xch_data[i+1] = up_data[i];
`ifdef SORT_IDX_EN
        xch_idx[i]    = up_idx[i+1];
        xch_idx[i+1]  = up_idx[i];
`endif
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    desc_d  = desc_q;
    data_d  = data_q;
`ifdef SORT_IDX_EN
    idx_d   = idx_q;
`endif
    if (load) begin
      valid_d = 1'b1;
      desc_d  = up_desc;
      data_d  = xch_data;
`ifdef SORT_IDX_EN
      idx_d   = xch_idx;
`endif
    end else if (dn_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      desc_q  <= 1'b0;
      data_q  <= '0;
`ifdef SORT_IDX_EN
      idx_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      desc_q  <= desc_d;
      data_q  <= data_d;
`ifdef SORT_IDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign dn_valid = valid_q;
  assign dn_desc  = desc_q;
  assign dn_data  = data_q;
`ifdef SORT_IDX_EN
  assign dn_idx   = idx_q;
`endif

endmodule

// File: rtl/oe_sort_pipe.sv
// oe_sort_pipe -- pipelined odd-even transposition sorter.
//
// DATA_N registered compare-exchange stages; stage k is even (pairs 0-1,
// 2-3..) for even k and odd (pairs 1-2, 3-4..) for odd k. Each vector
// carries its own direction bit, so ascending and descending vectors can
// be in flight together. Latency DATA_N cycles, one vector per cycle.
// out_data comes straight from the last stage's registers.
//
// Optional feature macro: SORT_IDX_EN -- tag every element with its input
// position and deliver the tags on bus.out_idx.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all stages
//   bus   : oe_sort_pipe_if.slave (input and output vector streams)
module oe_sort_pipe
  import sort_pkg::*;
#(
  parameter int DATA_N = 8,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  oe_sort_pipe_if.slave bus
);

`ifdef SORT_IDX_EN
  localparam int IDX_W = idx_w(DATA_N);
`endif

  // Per-stage signals live in their own generate scope so the ready chain,
  // which runs backwards from out_ready to in_ready, is a set of distinct
  // nets rather than one self-referencing vector.
  for (genvar k = 0; k < DATA_N; k++) begin : g_stage
    logic                           up_valid, up_ready, up_desc;
    logic                           dn_valid, dn_ready, dn_desc;
    logic [DATA_N-1:0][DATA_W-1:0]  up_data, dn_data;
`ifdef SORT_IDX_EN
    logic [DATA_N-1:0][IDX_W-1:0]   up_idx, dn_idx;
`endif

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_desc  = bus.in_desc;
      assign up_data  = bus.in_data;
`ifdef SORT_IDX_EN
      for (genvar i = 0; i < DATA_N; i++) begin : g_tag
        assign up_idx[i] = IDX_W'(i);
      end
`endif
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_desc  = g_stage[k-1].dn_desc;
      assign up_data  = g_stage[k-1].dn_data;
`ifdef SORT_IDX_EN
      assign up_idx   = g_stage[k-1].dn_idx;
`endif
    end

    if (k == DATA_N - 1) begin : g_tail
      assign dn_ready = bus.out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].up_ready;
    end

    sort_cas_stage #(
      .DATA_N (DATA_N),
      .DATA_W (DATA_W),
      .ODD    (k % 2 == 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_desc  (up_desc),
      .up_data  (up_data),
`ifdef SORT_IDX_EN
      .up_idx   (up_idx),
      .dn_idx   (dn_idx),
`endif
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_desc  (dn_desc),
      .dn_data  (dn_data)
    );
  end

  assign bus.in_ready  = g_stage[0].up_ready;
  assign bus.out_valid = g_stage[DATA_N-1].dn_valid;
  assign bus.out_data  = g_stage[DATA_N-1].dn_data;
`ifdef SORT_IDX_EN
  assign bus.out_idx   = g_stage[DATA_N-1].dn_idx;
`endif

endmodule

// File: tb/tb_oe_sort_pipe.sv
// tb_oe_sort_pipe -- directed checks on a 4x4 sorter plus a randomized
// handshake run on a 7x5 sorter against a stable insertion-sort model.
module tb_oe_sort_pipe;
  import sort_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oe_sort_pipe_if #(.DATA_N(4), .DATA_W(4)) b4 ();
  oe_sort_pipe_if #(.DATA_N(7), .DATA_W(5)) b7 ();

  oe_sort_pipe #(.DATA_N(4), .DATA_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  oe_sort_pipe #(.DATA_N(7), .DATA_W(5)) u_dut7 (.clk(clk), .rst_n(rst_n), .bus(b7));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk4(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [7:0] pki(input int i0, input int i1, input int i2, input int i3);
    return {2'(i3), 2'(i2), 2'(i1), 2'(i0)};
  endfunction

  // ---------------- 4x4 scoreboard / monitor ----------------
  logic [15:0] q4_dat[$];
  logic [7:0]  q4_idx[$];
  logic        stall4 = 1'b0;
  logic [15:0] held4;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        chk("hold_v", b4.out_valid, 1);
        chk("hold_d", b4.out_data, held4);
      end
      if (b4.out_valid && b4.out_ready) begin
        if (q4_dat.size() == 0) begin
          chk("unexp4", q4_dat.size(), 1);
        end else begin
          chk("dat4", b4.out_data, q4_dat.pop_front());
`ifdef SORT_IDX_EN
          chk("idx4", b4.out_idx, q4_idx.pop_front());
`else
          void'(q4_idx.pop_front());
`endif
        end
        stall4 = 1'b0;
      end else if (b4.out_valid) begin
        stall4 = 1'b1;
        held4  = b4.out_data;
      end else begin
        stall4 = 1'b0;
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 just after the transfer edge.
  task automatic send4(input logic [15:0] d, input logic desc,
                       input logic [15:0] ed, input logic [7:0] ei);
    b4.in_data  = d;
    b4.in_desc  = desc;
    b4.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (b4.in_ready) begin
        q4_dat.push_back(ed);
        q4_idx.push_back(ei);
        @(posedge clk); #2;
        b4.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #2;
    end
    chk("send_to", b4.in_ready, 1);
    b4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    for (int t = 0; t < 40 && q4_dat.size() != 0; t++) begin
      @(posedge clk); #2;
    end
    chk("drain4", q4_dat.size(), 0);
  endtask

  // ---------------- 7x5 reference model / monitor ----------------
  localparam int NV = 10000;
  logic [34:0] q7_dat[$];
  logic [20:0] q7_idx[$];
  int          n_rcv7 = 0;

  task automatic ref7(input logic [34:0] d, input logic desc,
                      output logic [34:0] od, output logic [20:0] oi);
    int k[7];
    int ix[7];
    int tk;
    int ti;
    for (int i = 0; i < 7; i++) begin
      k[i]  = int'(d[5*i +: 5]);
      ix[i] = i;
    end
    for (int i = 1; i < 7; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
          tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
          ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
        end else begin
          break;
        end
      end
    end
    od = '0;
    oi = '0;
    for (int i = 0; i < 7; i++) begin
      od[5*i +: 5] = 5'(k[i]);
      oi[3*i +: 3] = 3'(ix[i]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && b7.out_valid && b7.out_ready) begin
      if (q7_dat.size() == 0) begin
        chk("unexp7", q7_dat.size(), 1);
      end else begin
        chk("dat7", b7.out_data, q7_dat.pop_front());
`ifdef SORT_IDX_EN
        chk("idx7", b7.out_idx, q7_idx.pop_front());
`else
        void'(q7_idx.pop_front());
`endif
        n_rcv7++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          lat;
    int          sent;
    int          cyc;
    logic        have;
    logic [34:0] d7;
    logic [34:0] e7;
    logic [20:0] i7;
    logic        desc7;
    int          v;

    b4.in_valid  = 1'b0;
    b4.in_data   = '0;
    b4.in_desc   = 1'b0;
    b4.out_ready = 1'b1;
    b7.in_valid  = 1'b0;
    b7.in_data   = '0;
    b7.in_desc   = 1'b0;
    b7.out_ready = 1'b0;

    #1;
    chk("rst_rdy", b4.in_ready, 1);
    chk("rst_ov", b4.out_valid, 0);
    chk("rst_od", b4.out_data, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rel_rdy", b4.in_ready, 1);

    // latency and basic ascending sort
    send4(pk4(3, 1, 2, 0), 1'b0, pk4(0, 1, 2, 3), pki(3, 1, 2, 0));
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (b4.out_valid) break;
    end
    chk("lat1", lat, 4);
    @(posedge clk); #2;

    // back-to-back mixed directions, stability on equal keys
    send4(pk4(3, 1, 2, 0), 1'b1, pk4(3, 2, 1, 0), pki(0, 2, 1, 3));
    send4(pk4(9, 9, 1, 9), 1'b0, pk4(1, 9, 9, 9), pki(2, 0, 1, 3));
    drain4();

    // fill with out_ready low, then pass-through on a full pipe
    b4.out_ready = 1'b0;
    send4(pk4(4, 3, 2, 1),    1'b0, pk4(1, 2, 3, 4),    pki(3, 2, 1, 0));
    send4(pk4(5, 7, 6, 8),    1'b1, pk4(8, 7, 6, 5),    pki(3, 1, 2, 0));
    send4(pk4(15, 0, 10, 5),  1'b0, pk4(0, 5, 10, 15),  pki(1, 3, 2, 0));
    send4(pk4(2, 12, 1, 11),  1'b1, pk4(12, 11, 2, 1),  pki(1, 3, 0, 2));
    b4.in_data  = pk4(0, 1, 2, 3);
    b4.in_desc  = 1'b0;
    b4.in_valid = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk("full_rdy", b4.in_ready, 0);
      @(posedge clk); #2;
    end
    b4.out_ready = 1'b1;
    @(negedge clk);
    chk("full_pass_rdy", b4.in_ready, 1);
    chk("full_pass_ov", b4.out_valid, 1);
    q4_dat.push_back(pk4(0, 1, 2, 3));
    q4_idx.push_back(pki(0, 1, 2, 3));
    @(posedge clk); #2;
    b4.in_valid = 1'b0;
    send4(pk4(3, 2, 1, 0), 1'b0, pk4(0, 1, 2, 3), pki(3, 2, 1, 0));
    drain4();

    // reset with vectors in flight
    b4.out_ready = 1'b0;
    send4(pk4(4, 3, 2, 1),   1'b0, pk4(1, 2, 3, 4),   pki(3, 2, 1, 0));
    send4(pk4(5, 7, 6, 8),   1'b1, pk4(8, 7, 6, 5),   pki(3, 1, 2, 0));
    send4(pk4(15, 0, 10, 5), 1'b0, pk4(0, 5, 10, 15), pki(1, 3, 2, 0));
    repeat (2) @(negedge clk);
    chk("pre_rst_ov", b4.out_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    q4_dat.delete();
    q4_idx.delete();
    #1;
    chk("rst_ov2", b4.out_valid, 0);
    chk("rst_od2", b4.out_data, 0);
    chk("rst_rdy2", b4.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    b4.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("no_stale", b4.out_valid, 0);
    end
    @(posedge clk); #2;
    send4(pk4(6, 14, 3, 9), 1'b1, pk4(14, 9, 6, 3), pki(1, 3, 0, 2));
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (b4.out_valid) break;
    end
    chk("lat2", lat, 4);
    @(posedge clk); #2;
    drain4();

    // randomized handshake on the 7x5 instance
    sent = 0;
    cyc  = 0;
    have = 1'b0;
    v    = 0;
    while (n_rcv7 < NV && cyc < 80000) begin
      @(posedge clk); #2;
      cyc++;
      if (!have) b7.in_valid = 1'b0;
      b7.out_ready = 1'($urandom_range(1, 0));
      if (!have && sent < NV && $urandom_range(1, 0) == 1) begin
        for (int i = 0; i < 7; i++) begin
          d7[5*i +: 5] = (v % 2 == 1) ? 5'($urandom_range(7, 0)) : 5'($urandom_range(31, 0));
        end
        desc7 = 1'($urandom_range(1, 0));
        v++;
        b7.in_data  = d7;
        b7.in_desc  = desc7;
        b7.in_valid = 1'b1;
        have = 1'b1;
      end
      @(negedge clk);
      if (have && b7.in_ready) begin
        ref7(d7, desc7, e7, i7);
        q7_dat.push_back(e7);
        q7_idx.push_back(i7);
        sent++;
        have = 1'b0;
      end
    end
    b7.in_valid = 1'b0;
    chk("rand_cnt", n_rcv7, NV);
    chk("rand_left", q7_dat.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
